// File: rtl/aes_key_expansion_if.sv
// ---------------------------------------------------------------------------
// aes_key_expansion_if
// Bundles the request/status/read-port signals of the AES-128 key schedule.
//
// Handshake: start is a single-cycle request. It is accepted on the rising
// edge where the schedule is not busy (IDLE or READY). A start seen while
// busy is dropped, not queued. done pulses for one cycle when keys_valid
// rises. round_key is a combinational read of rk[round_sel]. Readers must
// qualify it with keys_valid.
//
// Signals
//   start      requester -> schedule  expand key_in
//   key_in     requester -> schedule  128-bit cipher key
//   round_sel  requester -> schedule  round key index 0..10
//   busy       schedule  -> requester expansion in progress
//   done       schedule  -> requester one-cycle completion pulse
//   keys_valid schedule  -> requester all 11 round keys readable
//   round_key  schedule  -> requester rk[round_sel], zero beyond 10
//   state_dbg  schedule  -> requester FSM state, for observation only
// ---------------------------------------------------------------------------
interface aes_key_expansion_if;
   logic         start;
   logic [127:0] key_in;
   logic [3:0]   round_sel;
   logic         busy;
   logic         done;
   logic         keys_valid;
   logic [127:0] round_key;
   logic [1:0]   state_dbg;

   modport master (
      output start, key_in, round_sel,
      input  busy, done, keys_valid, round_key, state_dbg
   );

   modport slave (
      input  start, key_in, round_sel,
      output busy, done, keys_valid, round_key, state_dbg
   );
endinterface

// File: rtl/aes_key_expansion.sv
// ---------------------------------------------------------------------------
// aes_key_expansion
// Iterative AES-128 key schedule. It produces one round key per clock into
// an 11-entry register file. The register file is read through a
// combinational indexed port. Byte 0 is bits [127:120] and word w0 is
// bits [127:96].
//
// Ports
//   clk  rising-edge clock
//   rst  synchronous, active-high reset
//   kx   aes_key_expansion_if.slave (start/key_in/round_sel in;
//        busy/done/keys_valid/round_key/state_dbg out)
// ---------------------------------------------------------------------------
module aes_key_expansion (
   input  logic                 clk,
   input  logic                 rst,
   aes_key_expansion_if.slave   kx
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXPAND = 2'd1,
      READY  = 2'd2
   } state_e;

   // FIPS-197 forward S-box. Entry 0 occupies the top byte.
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      int idx;
      idx  = 255 - int'(b);
      sbox = SBOX_TABLE[idx*8 +: 8];
   endfunction

   state_e       state_q, state_d;
   logic [127:0] rk_q [0:10];
   logic [3:0]   cnt_q, cnt_d;
   logic [7:0]   rcon_q, rcon_d;
   logic         done_q, done_d;

   logic         wr_en;
   logic [3:0]   wr_idx;
   logic [127:0] wr_data;

   logic [3:0]   prev_idx;
   logic [127:0] prev;
   logic [31:0]  w0, w1, w2, w3, rot, t, n0, n1, n2, n3;
   logic [7:0]   rcon_next;

   // Round datapath. prev is the key written on the previous edge. The
   // index guard only keeps the read inside the file while cnt is 0 in
   // IDLE.
   always_comb begin
      prev_idx = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
      prev     = rk_q[prev_idx];
      w0       = prev[127:96];
      w1       = prev[95:64];
      w2       = prev[63:32];
      w3       = prev[31:0];
      rot      = {w3[23:0], w3[31:24]};
      t        = {sbox(rot[31:24]), sbox(rot[23:16]),
                  sbox(rot[15:8]),  sbox(rot[7:0])} ^ {rcon_q, 24'h0};
      n0       = w0 ^ t;
      n1       = w1 ^ n0;
      n2       = w2 ^ n1;
      n3       = w3 ^ n2;
      // xtime in GF(2^8)
      rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rcon_d  = rcon_q;
      done_d  = 1'b0;
      wr_en   = 1'b0;
      wr_idx  = cnt_q;
      wr_data = {n0, n1, n2, n3};
      case (state_q)
         IDLE, READY: begin
            if (kx.start) begin
               state_d = EXPAND;
               cnt_d   = 4'd1;
               rcon_d  = 8'h01;
               wr_en   = 1'b1;
               wr_idx  = 4'd0;
               wr_data = kx.key_in;
            end
         end
         EXPAND: begin
            // start is deliberately not looked at here.
            wr_en  = 1'b1;
            rcon_d = rcon_next;
            cnt_d  = cnt_q + 4'd1;
            if (cnt_q == 4'd10) begin
               state_d = READY;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         rcon_q  <= 8'h01;
         done_q  <= 1'b0;
         for (int i = 0; i < 11; i++) rk_q[i] <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rcon_q  <= rcon_d;
         done_q  <= done_d;
         if (wr_en) rk_q[wr_idx] <= wr_data;
      end
   end

   assign kx.busy       = (state_q == EXPAND);
   assign kx.keys_valid = (state_q == READY);
   assign kx.done       = done_q;
   assign kx.state_dbg  = state_q;
   assign kx.round_key  = (kx.round_sel > 4'd10) ? '0 : rk_q[kx.round_sel];

endmodule

// File: tb/tb_aes_key_expansion.sv
module tb_aes_key_expansion;

  localparam int W = 128;
  localparam logic [W-1:0] KEY_A1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [W-1:0] RK1_A1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [W-1:0] RK10_A1 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [W-1:0] KEY_Z   = 128'h0;
  localparam logic [W-1:0] RK1_Z   = 128'h62636363626363636263636362636363;
  localparam logic [W-1:0] RK10_Z  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [W-1:0] KEY_FF  = {W{1'b1}};

  logic clk;
  logic rst;
  aes_key_expansion_if kx ();

  aes_key_expansion dut (
    .clk (clk),
    .rst (rst),
    .kx  (kx.slave)
  );

  // round_sel is shared between the monitor and the driver.
  logic       mon_owns;
  logic [3:0] mon_sel;
  logic [3:0] drv_sel;
  assign kx.round_sel = mon_owns ? mon_sel : drv_sel;

  int tests_run;
  int tests_failed;
  int done_cnt;
  logic [W-1:0] exp_q[$];

  // ---------------- clock/reset ----------------
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- common check ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_expect(input logic [W-1:0] k0, input logic [W-1:0] k1, input logic [W-1:0] k10);
    exp_q.push_back(k0);
    exp_q.push_back(k1);
    exp_q.push_back(k10);
  endtask

  // Called at a negedge; returns at the following negedge with start low.
  task automatic start_pulse(input logic [W-1:0] key);
    kx.start  = 1'b1;
    kx.key_in = key;
    @(negedge clk);
    kx.start  = 1'b0;
  endtask

  // Counts negedges until done is seen; a timeout is a failed comparison.
  task automatic wait_done(input int already, output int cycles);
    cycles = already;
    while (cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (kx.done === 1'b1) break;
    end
    if (kx.done !== 1'b1) begin
      tests_run++;
      tests_failed++;
      $display("FAIL done_timeout: got no done within %0d cycles, required done", cycles);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    mon_owns = 1'b0;
    mon_sel  = 4'd0;
    forever begin
      @(negedge clk);
      if (kx.done === 1'b1) begin
        done_cnt++;
        if (exp_q.size() < 3) begin
          tests_run++;
          tests_failed++;
          $display("FAIL done_unexpected: got done with %0d queued, required none", exp_q.size());
        end else begin
          mon_owns = 1'b1;
          mon_sel = 4'd0;  #1 check("rk0",  kx.round_key, exp_q.pop_front());
          mon_sel = 4'd1;  #1 check("rk1",  kx.round_key, exp_q.pop_front());
          mon_sel = 4'd10; #1 check("rk10", kx.round_key, exp_q.pop_front());
          for (int s = 11; s < 16; s++) begin
            mon_sel = 4'(s);
            #1 check("rk_oob", kx.round_key, '0);
          end
          check("valid_at_done", W'(kx.keys_valid), W'(1));
          check("busy_at_done",  W'(kx.busy),       W'(0));
          mon_owns = 1'b0;
        end
        @(negedge clk);
        check("done_width", W'(kx.done), W'(0));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int d0;
    tests_run    = 0;
    tests_failed = 0;
    done_cnt     = 0;
    rst          = 1'b1;
    kx.start     = 1'b0;
    kx.key_in    = '0;
    drv_sel      = 4'd0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy",  W'(kx.busy),       W'(0));
    check("rst_done",  W'(kx.done),       W'(0));
    check("rst_valid", W'(kx.keys_valid), W'(0));
    for (int s = 0; s < 16; s += 5) begin
      drv_sel = 4'(s);
      #1 check("rst_rk", kx.round_key, '0);
    end
    rst = 1'b0;
    @(negedge clk);

    // FIPS-197 A.1
    push_expect(KEY_A1, RK1_A1, RK10_A1);
    start_pulse(KEY_A1);
    check("a1_busy", W'(kx.busy), W'(1));
    wait_done(1, lat);
    check("a1_latency", W'(lat), W'(11));
    @(negedge clk);

    // Restart from READY with the zero key
    push_expect(KEY_Z, RK1_Z, RK10_Z);
    start_pulse(KEY_Z);
    check("ready_restart_valid", W'(kx.keys_valid), W'(0));
    check("ready_restart_busy",  W'(kx.busy),       W'(1));
    wait_done(1, lat);
    check("zero_latency", W'(lat), W'(11));
    @(negedge clk);
    // Full sweep 0..15 by the driver: rk0 is zero, 11..15 must be zero
    drv_sel = 4'd0;
    #1 check("zero_sweep_rk0", kx.round_key, KEY_Z);
    for (int s = 11; s < 16; s++) begin
      drv_sel = 4'(s);
      #1 check("zero_sweep_oob", kx.round_key, '0);
    end

    // start re-pulsed at E5 is ignored
    d0 = done_cnt;
    push_expect(KEY_A1, RK1_A1, RK10_A1);
    start_pulse(KEY_A1);
    repeat (4) @(negedge clk);
    kx.start  = 1'b1;
    kx.key_in = KEY_FF;
    @(negedge clk);
    kx.start  = 1'b0;
    wait_done(6, lat);
    check("ignore_latency", W'(lat), W'(11));
    repeat (15) @(negedge clk);
    check("ignore_done_once", W'(done_cnt - d0), W'(1));
    check("ignore_ready", W'(kx.keys_valid), W'(1));

    // Reset at E6 of an expansion
    d0 = done_cnt;
    start_pulse(KEY_Z);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy",  W'(kx.busy),       W'(0));
    check("midrst_valid", W'(kx.keys_valid), W'(0));
    for (int s = 0; s < 11; s++) begin
      drv_sel = 4'(s);
      #1 check("midrst_rk", kx.round_key, '0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("midrst_no_done", W'(done_cnt - d0), W'(0));
    push_expect(KEY_A1, RK1_A1, RK10_A1);
    start_pulse(KEY_A1);
    wait_done(1, lat);
    check("postrst_latency", W'(lat), W'(11));
    @(negedge clk);

    // start held high: restart every 11 cycles
    d0 = done_cnt;
    for (int r = 0; r < 3; r++) push_expect(KEY_A1, RK1_A1, RK10_A1);
    kx.key_in = KEY_A1;
    kx.start  = 1'b1;
    for (int r = 0; r < 3; r++) begin
      wait_done(0, lat);
      check("b2b_period", W'(lat), W'(11));
    end
    kx.start = 1'b0;
    repeat (15) @(negedge clk);
    check("b2b_done_count", W'(done_cnt - d0), W'(3));
    check("scoreboard_empty", W'(exp_q.size()), W'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
